pipe_scroller: RTL and testbench

- Consumes the 16-bit pipe columns from the upstream pipe generator and keeps a 16x16 scrolling playfield.
- Each game tick shifts the field one column left and loads the new pipe column at the right edge.
- Detects when the bird hits a pipe, and counts pipes the bird has passed.
- Feeds the LED-matrix driver through a column read port, and feeds the game-control logic with status and score.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_field.sv | 39 +++
 rtl/pipe_scroller.sv | 106 ++++++++++
 tb/tb_pipe_scroller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the scrolling pipe playfield.
package pipe_pkg;

  typedef logic [15:0] column_t;
  typedef column_t [15:0] field_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CRASH
  } game_state_t;

  localparam int FIELD_COLS = 16;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  // Increment that sticks at the top of the score range instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == SCORE_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pipe_field.sv
// 16-column scrolling playfield: shift-left register with a clear control,
// a registered display read port and a combinational tap on the bird column.
module pipe_field
  import pipe_pkg::*;
#(
  parameter int BIRD_COL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift,
  input  column_t    column_in,
  input  logic [3:0] disp_col,
  output column_t    disp_pixels,
  output column_t    bird_column
);

  localparam int LAST_COL = FIELD_COLS - 1;

  field_t field;

  // Field storage and display read; the read samples the field before any same-edge update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field       <= '0;
      disp_pixels <= '0;
    end else begin
      disp_pixels <= field[disp_col];
      if (clear) begin
        field <= '0;
      end else if (shift) begin
        field <= {column_in, field[LAST_COL:1]};
      end
    end
  end

  assign bird_column = field[BIRD_COL];

endmodule

// File: rtl/pipe_scroller.sv
// Game-level wrapper around the playfield: IDLE/RUN/CRASH control,
// collision detection at the bird column and the saturating pipe score.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int BIRD_COL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        shift_en,
  input  logic [15:0] column_in,
  input  logic [3:0]  bird_row,
  input  logic [3:0]  disp_col,
  output logic [15:0] disp_pixels,
  output logic        running,
  output logic        crashed,
  output logic [7:0]  score
);

  game_state_t state;
  game_state_t state_next;

  column_t bird_column;
  logic    hit;
  logic    field_clear;
  logic    field_shift;
  logic    score_clear;
  logic    score_inc;

  pipe_field #(
    .BIRD_COL(BIRD_COL)
  ) u_field (
    .clk        (clk),
    .rst        (rst),
    .clear      (field_clear),
    .shift      (field_shift),
    .column_in  (column_in),
    .disp_col   (disp_col),
    .disp_pixels(disp_pixels),
    .bird_column(bird_column)
  );

  assign hit = bird_column[bird_row];

  // Next-state and datapath controls; a hit blocks the shift, and start beats shift_en.
  always_comb begin
    state_next  = state;
    field_clear = 1'b0;
    field_shift = 1'b0;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        field_clear = 1'b1;
        if (start) begin
          state_next  = RUN;
          score_clear = 1'b1;
        end
      end
      RUN: begin
        if (hit) begin
          state_next = CRASH;
        end else if (shift_en) begin
          field_shift = 1'b1;
          score_inc   = (bird_column != '0);
        end
      end
      CRASH: begin
        if (start) begin
          state_next  = RUN;
          field_clear = 1'b1;
          score_clear = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with status flags decoded from the upcoming state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
      crashed <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      crashed <= (state_next == CRASH);
    end
  end

  // Score counter: cleared on game start, bumped when a pipe leaves the bird column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= '0;
    end else if (score_clear) begin
      score <= '0;
    end else if (score_inc) begin
      score <= sat_inc(score);
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: directed scenarios plus random play,
// compared every cycle against an array-based model of the game rules.
module tb_pipe_scroller;

  localparam int BIRD_COL = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CRASH = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        shift_en;
  logic [15:0] column_in;
  logic [3:0]  bird_row;
  logic [3:0]  disp_col;
  logic [15:0] disp_pixels;
  logic        running;
  logic        crashed;
  logic [7:0]  score;

  int checks;
  int errors;

  logic [15:0] m_field [16];
  int          m_score;
  int          m_mode;
  logic [15:0] m_disp;

  pipe_scroller #(
    .BIRD_COL(BIRD_COL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_en   (shift_en),
    .column_in  (column_in),
    .bird_row   (bird_row),
    .disp_col   (disp_col),
    .disp_pixels(disp_pixels),
    .running    (running),
    .crashed    (crashed),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < 16; c++) m_field[c] = 16'h0000;
  endtask

  // Game rules applied to one clock edge using the pre-edge field.
  task automatic modelEdge(input logic st, input logic sh, input logic [15:0] col,
                           input logic [3:0] br, input logic [3:0] dc);
    m_disp = m_field[dc];
    case (m_mode)
      M_IDLE: begin
        if (st) begin
          m_mode  = M_RUN;
          m_score = 0;
          modelClear();
        end
      end
      M_RUN: begin
        if (m_field[BIRD_COL][br]) begin
          m_mode = M_CRASH;
        end else if (sh) begin
          if (m_field[BIRD_COL] != 16'h0000 && m_score < 255) m_score = m_score + 1;
          for (int c = 0; c < 15; c++) m_field[c] = m_field[c+1];
          m_field[15] = col;
        end
      end
      default: begin
        if (st) begin
          m_mode  = M_RUN;
          m_score = 0;
          modelClear();
        end
      end
    endcase
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".running"}, {15'd0, running}, {15'd0, m_mode == M_RUN});
    checkOutput({tag, ".crashed"}, {15'd0, crashed}, {15'd0, m_mode == M_CRASH});
    checkOutput({tag, ".score"}, {8'd0, score}, m_score[15:0]);
    checkOutput({tag, ".disp"}, disp_pixels, m_disp);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare.
  task automatic applyStimulus(input string tag, input logic st, input logic sh,
                               input logic [15:0] col, input logic [3:0] br,
                               input logic [3:0] dc);
    start     = st;
    shift_en  = sh;
    column_in = col;
    bird_row  = br;
    disp_col  = dc;
    @(posedge clk);
    modelEdge(st, sh, col, br, dc);
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset between edges, checked before any clock arrives.
  task automatic doReset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    m_mode  = M_IDLE;
    m_score = 0;
    m_disp  = 16'h0000;
    modelClear();
    checkAll(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int d = 0; d < 16; d++) applyStimulus("reset_read", 1'b0, 1'b0, 16'h0, 4'd0, d[3:0]);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    shift_en  = 1'b0;
    column_in = 16'h0;
    bird_row  = 4'd0;
    disp_col  = 4'd0;
    m_mode    = M_IDLE;
    m_score   = 0;
    m_disp    = 16'h0000;
    modelClear();

    #2;
    checkAll("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // IDLE ignores shift_en
    applyStimulus("idle_shift", 1'b0, 1'b1, 16'hFFFF, 4'd0, 4'd15);
    applyStimulus("idle_read", 1'b0, 1'b0, 16'h0, 4'd0, 4'd15);

    // Basic scroll with the display following the column leftwards
    applyStimulus("start", 1'b1, 1'b0, 16'h0, 4'd0, 4'd0);
    applyStimulus("scroll_in", 1'b0, 1'b1, 16'h00F0, 4'd0, 4'd15);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus("scroll", 1'b0, 1'b1, 16'h0, 4'd0, 4'(16 - k));
      if (k < 16) checkOutput("scroll_col", disp_pixels, 16'h00F0);
    end
    for (int d = 0; d < 16; d++) applyStimulus("scroll_empty", 1'b0, 1'b0, 16'h0, 4'd0, d[3:0]);
    checkOutput("scroll_score", {8'd0, score}, 16'd1);

    // Pass and score with bird_row 2 (bit 2 of 00F0 is clear)
    applyStimulus("pass_in", 1'b0, 1'b1, 16'h00F0, 4'd2, 4'd0);
    for (int k = 0; k < 13; k++) applyStimulus("pass", 1'b0, 1'b1, 16'h0, 4'd2, 4'd3);
    checkOutput("pass_nocrash", {15'd0, crashed}, 16'd0);
    checkOutput("pass_score", {8'd0, score}, 16'd2);

    // Collision at bird_row 5, with shift_en on the crash edge
    applyStimulus("coll_in", 1'b0, 1'b1, 16'h00F0, 4'd5, 4'd0);
    for (int k = 0; k < 12; k++) applyStimulus("coll_scroll", 1'b0, 1'b1, 16'h0, 4'd5, 4'd0);
    checkOutput("coll_notyet", {15'd0, crashed}, 16'd0);
    applyStimulus("coll_hit", 1'b0, 1'b1, 16'h0, 4'd5, 4'd3);
    checkOutput("coll_crashed", {15'd0, crashed}, 16'd1);
    for (int k = 0; k < 3; k++) applyStimulus("crash_frozen", 1'b0, 1'b1, 16'hFFFF, 4'd5, 4'd3);
    checkOutput("crash_disp", disp_pixels, 16'h00F0);
    checkOutput("crash_score", {8'd0, score}, 16'd2);

    // start with shift_en in CRASH restarts on a clean field
    applyStimulus("restart", 1'b1, 1'b1, 16'hFFFF, 4'd5, 4'd3);
    applyStimulus("restart_read", 1'b0, 1'b0, 16'h0, 4'd5, 4'd3);
    checkOutput("restart_field", disp_pixels, 16'h0000);
    checkOutput("restart_score", {8'd0, score}, 16'd0);

    // Random play
    for (int k = 0; k < 400; k++) begin
      logic        st;
      logic        sh;
      logic [15:0] col;
      st  = ($urandom_range(0, 19) == 0);
      sh  = ($urandom_range(0, 1) == 1);
      col = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      applyStimulus("random", st, sh, col, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    doReset("reset_random");

    // Saturation: a pipe with only row 15 set passes every tick
    applyStimulus("sat_start", 1'b1, 1'b0, 16'h0, 4'd0, 4'd0);
    for (int k = 0; k < 275; k++) applyStimulus("sat", 1'b0, 1'b1, 16'h8000, 4'd0, 4'(k));
    checkOutput("sat_score", {8'd0, score}, 16'd255);
    checkOutput("sat_running", {15'd0, running}, 16'd1);

    // Mid-game asynchronous reset with a populated field
    doReset("reset_midgame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
